// File: rtl/sysid_pkg.sv
// Shared types and constants for the system-ID check master.
package sysid_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ_ID,
    WAIT_ID,
    REQ_TS,
    WAIT_TS,
    EVAL
  } sysid_state_t;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [31:0] DEFAULT_EXPECTED_ID = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_EXPECTED_TS = 32'h5537_8402;

endpackage

// File: rtl/sysid_check_master.sv
// Reads the sysid slave (ID word, then build timestamp), compares both against
// build-time values and holds sticky done/pass/mismatch/timeout results.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | waiting for start or the pending auto-start
//   REQ_ID  | read strobe on word 0, held through waitrequest
//   WAIT_ID | counting read latency for word 0
//   REQ_TS  | read strobe on word 1, held through waitrequest
//   WAIT_TS | counting read latency for word 1
//   EVAL    | results visible, busy low; returns to IDLE
module sysid_check_master
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID    = DEFAULT_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS    = DEFAULT_EXPECTED_TS,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        id_mismatch,
  output logic        ts_mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]  LAT_LAST  = 2'(READ_LATENCY - 1);

  sysid_state_t state, state_n;
  logic [15:0]  wait_cnt, wait_n;
  logic [1:0]   lat_cnt, lat_n;
  logic         auto_pend, auto_n;
  logic         busy_n, done_n, pass_n, id_mm_n, ts_mm_n, to_n;
  logic [31:0]  id_n, ts_n, ts_word;
  logic         finish, id_read, ts_read;

  always_comb begin
    state_n     = state;
    wait_n      = wait_cnt;
    lat_n       = lat_cnt;
    auto_n      = auto_pend;
    busy_n      = busy;
    done_n      = done;
    pass_n      = pass;
    id_mm_n     = id_mismatch;
    ts_mm_n     = ts_mismatch;
    to_n        = timeout;
    id_n        = id_value;
    ts_n        = ts_value;
    ts_word     = ts_value;
    finish      = 1'b0;
    id_read     = 1'b0;
    ts_read     = 1'b0;
    avm_read    = 1'b0;
    avm_address = SYSID_ADDR_ID;

    case (state)
      IDLE: begin
        if (start || auto_pend) begin
          state_n = REQ_ID;
          auto_n  = 1'b0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
          pass_n  = 1'b0;
          id_mm_n = 1'b0;
          ts_mm_n = 1'b0;
          to_n    = 1'b0;
          id_n    = '0;
          ts_n    = '0;
          wait_n  = '0;
          lat_n   = '0;
        end
      end
      REQ_ID: begin
        avm_read    = 1'b1;
        avm_address = SYSID_ADDR_ID;
        if (avm_waitrequest) begin
          if (wait_cnt == WAIT_LAST) begin
            to_n   = 1'b1;
            finish = 1'b1;
          end else begin
            wait_n = wait_cnt + 16'd1;
          end
        end else begin
          wait_n = '0;
          lat_n  = '0;
          if (READ_LATENCY == 0) begin
            id_n    = avm_readdata;
            state_n = REQ_TS;
          end else begin
            state_n = WAIT_ID;
          end
        end
      end
      WAIT_ID: begin
        if (lat_cnt == LAT_LAST) begin
          id_n    = avm_readdata;
          state_n = REQ_TS;
        end else begin
          lat_n = lat_cnt + 2'd1;
        end
      end
      REQ_TS: begin
        avm_read    = 1'b1;
        avm_address = SYSID_ADDR_TS;
        id_read     = 1'b1;
        if (avm_waitrequest) begin
          if (wait_cnt == WAIT_LAST) begin
            to_n   = 1'b1;
            finish = 1'b1;
          end else begin
            wait_n = wait_cnt + 16'd1;
          end
        end else begin
          wait_n = '0;
          lat_n  = '0;
          if (READ_LATENCY == 0) begin
            ts_read = 1'b1;
            ts_word = avm_readdata;
            ts_n    = avm_readdata;
            finish  = 1'b1;
          end else begin
            state_n = WAIT_TS;
          end
        end
      end
      WAIT_TS: begin
        id_read = 1'b1;
        if (lat_cnt == LAT_LAST) begin
          ts_read = 1'b1;
          ts_word = avm_readdata;
          ts_n    = avm_readdata;
          finish  = 1'b1;
        end else begin
          lat_n = lat_cnt + 2'd1;
        end
      end
      EVAL:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    // Results are registered on entry to EVAL so they are visible during it;
    // a word skipped by a timeout never raises its mismatch flag.
    if (finish) begin
      state_n = EVAL;
      busy_n  = 1'b0;
      done_n  = 1'b1;
      id_mm_n = id_read && (id_value != EXPECTED_ID);
      ts_mm_n = ts_read && (ts_word != EXPECTED_TS);
      pass_n  = !to_n && !id_mm_n && !ts_mm_n;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      lat_cnt     <= '0;
      auto_pend   <= AUTO_START;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      id_mismatch <= 1'b0;
      ts_mismatch <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      state       <= state_n;
      wait_cnt    <= wait_n;
      lat_cnt     <= lat_n;
      auto_pend   <= auto_n;
      busy        <= busy_n;
      done        <= done_n;
      pass        <= pass_n;
      id_mismatch <= id_mm_n;
      ts_mismatch <= ts_mm_n;
      timeout     <= to_n;
      id_value    <= id_n;
      ts_value    <= ts_n;
    end
  end

endmodule
